// File: rtl/avgpool_div_pkg.sv
// avgpool_div_pkg: constants and FSM encoding shared by the averaging divider.
//   FRAC_BITS : fractional bits of the reciprocal table (Q3.13).
//   ROUND     : half-LSB added before the final arithmetic shift.
//   ROM_DEPTH : number of reciprocal entries (window sizes 1..64).
package avgpool_div_pkg;

    localparam int unsigned FRAC_BITS = 13;
    localparam int unsigned ROUND     = 4096;
    localparam int unsigned ROM_DEPTH = 64;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned FRAC_W    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMul,
        StRnd,
        StOut
    } state_e;

endpackage

// File: rtl/avgpool_recip_rom.sv
// avgpool_recip_rom: reciprocal table, entry i = floor(8192 / (i + 1)).
// Ports:
//   clk_i  : clock
//   idx_i  : window size minus one (0..63)
//   frac_o : registered Q3.13 reciprocal, valid one cycle after idx_i
module avgpool_recip_rom
    import avgpool_div_pkg::*;
(
    input  logic              clk_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [FRAC_W-1:0] frac_o
);

    logic [FRAC_W-1:0] rom_tbl [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_tbl
        assign rom_tbl[i] = FRAC_W'((1 << FRAC_BITS) / (i + 1));
    end

    // No reset: the value is only consumed one cycle after a valid index.
    always_ff @(posedge clk_i) begin
        frac_o <= rom_tbl[idx_i];
    end

endmodule

// File: rtl/avgpool_div_arb.sv
// avgpool_div_arb: round-robin arbiter feeding one shared window-average unit.
// A granted requester's sum is multiplied by a reciprocal of its window size,
// rounded, saturated and presented on the output until accepted.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready one-hot or zero)
//   req_sum              : NREQ signed DW-bit window sums, slice i = requester i
//   req_cnt              : NREQ 6-bit window sizes minus one
//   out_valid/out_ready  : result handshake
//   out_data, out_id     : signed average and owning requester index
//   busy                 : high whenever a transaction is in flight
module avgpool_div_arb
    import avgpool_div_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 24,
    parameter int unsigned OW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_sum,
    input  logic [NREQ*6-1:0] req_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_data,
    output logic [2:0]        out_id,
    output logic              busy
);

    localparam int unsigned PW = DW + 17;

    localparam logic signed [PW-1:0] RoundC = PW'(ROUND);
    localparam logic signed [PW-1:0] OutMax = {{(PW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [PW-1:0] OutMin = {{(PW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

    state_e state_q, state_d;

    logic [2:0]             ptr_q, ptr_d;
    logic signed [DW-1:0]   sum_q;
    logic [IDX_W-1:0]       idx_q;
    logic [2:0]             id_q;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic [OW-1:0]          out_data_q, out_data_d;
    logic [2:0]             out_id_q;

    logic [FRAC_W-1:0]      frac;
    logic [2:0]             grant;
    logic                   grant_vld;
    logic [DW-1:0]          sum_sel;
    logic [IDX_W-1:0]       cnt_sel;
    logic                   accept;
    logic signed [PW-1:0]   sum_ext, frac_ext, rnd_full;

    // Round-robin search: first valid at or above ptr, else first valid below it.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!grant_vld && req_valid[i] && i >= int'(ptr_q)) begin
                grant     = 3'(i);
                grant_vld = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!grant_vld && req_valid[i] && i < int'(ptr_q)) begin
                grant     = 3'(i);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sum_sel = '0;
        cnt_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant == 3'(i)) begin
                sum_sel = req_sum[i*DW +: DW];
                cnt_sel = req_cnt[i*6 +: 6];
            end
        end
    end

    assign accept = (state_q == StIdle) && grant_vld;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant == 3'(NREQ - 1)) ? 3'd0 : grant + 3'd1;
        end
    end

    avgpool_recip_rom u_rom (
        .clk_i  (clk),
        .idx_i  (idx_q),
        .frac_o (frac)
    );

    // Signed sum times zero-extended unsigned fraction.
    assign sum_ext  = PW'(sum_q);
    assign frac_ext = $signed(PW'(frac));
    assign prod_d   = sum_ext * frac_ext;

    assign rnd_full = (prod_q + RoundC) >>> FRAC_BITS;

    always_comb begin
        if (rnd_full > OutMax) begin
            out_data_d = OutMax[OW-1:0];
        end else if (rnd_full < OutMin) begin
            out_data_d = OutMin[OW-1:0];
        end else begin
            out_data_d = rnd_full[OW-1:0];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_vld) state_d = StLookup;
            StLookup: state_d = StMul;
            StMul:    state_d = StRnd;
            StRnd:    state_d = StOut;
            StOut:    if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs; ready is also held low while reset is asserted
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_vld && rst_n) begin
            req_ready = NREQ'(1) << grant;
        end
        out_valid = (state_q == StOut);
        busy      = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            id_q       <= '0;
            prod_q     <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                sum_q <= $signed(sum_sel);
                idx_q <= cnt_sel;
                id_q  <= grant;
            end
            if (state_q == StMul) begin
                prod_q <= prod_d;
            end
            if (state_q == StRnd) begin
                out_data_q <= out_data_d;
                out_id_q   <= id_q;
            end
        end
    end

    assign out_data = out_data_q;
    assign out_id   = out_id_q;

endmodule

// File: tb/tb_avgpool_div_arb.sv
module tb_avgpool_div_arb;

    localparam int NREQ = 4;
    localparam int DW   = 24;
    localparam int OW   = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DW-1:0]    req_sum;
    logic [NREQ*6-1:0]     req_cnt;
    logic                  out_valid;
    logic                  out_ready;
    logic [OW-1:0]         out_data;
    logic [2:0]            out_id;
    logic                  busy;

    int tests = 0;
    int fails = 0;

    avgpool_div_arb #(.NREQ(NREQ), .DW(DW), .OW(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sum   (req_sum),
        .req_cnt   (req_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: average = round-half-up(sum * floor(8192/n) / 8192), saturated.
    function automatic longint model_avg(input longint s, input int c);
        longint p, q, lim;
        lim = longint'(1) <<< (OW - 1);
        p = s * longint'(8192 / (c + 1));
        q = p + 4096;
        q = q >>> 13;
        if (q > lim - 1) q = lim - 1;
        if (q < -lim) q = -lim;
        return q;
    endfunction

    // Transaction-level model: idle/in-flight, age since handshake, expected result.
    int     m_ptr = 0;
    bit     m_busy = 0;
    int     m_age = 0;
    int     m_id = 0;
    longint m_data = 0;

    always @(negedge clk) begin
        int g;
        longint exp_ready;
        if (!rst_n) begin
            chk("rst_ready", longint'(req_ready), 0);
            chk("rst_busy", longint'(busy), 0);
            chk("rst_valid", longint'(out_valid), 0);
            chk("rst_data", longint'($signed(out_data)), 0);
            chk("rst_id", longint'(out_id), 0);
            m_busy = 0;
            m_ptr = 0;
        end else if (!m_busy) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[j]) g = j;
            end
            exp_ready = (g >= 0) ? (longint'(1) << g) : 0;
            chk("idle_ready", longint'(req_ready), exp_ready);
            chk("idle_busy", longint'(busy), 0);
            chk("idle_valid", longint'(out_valid), 0);
            if (g >= 0) begin
                m_busy = 1;
                m_age = 0;
                m_id = g;
                m_data = model_avg(longint'($signed(req_sum[g*DW +: DW])),
                                   int'(req_cnt[g*6 +: 6]));
                m_ptr = (g + 1) % NREQ;
            end
        end else begin
            m_age++;
            chk("run_busy", longint'(busy), 1);
            chk("run_ready", longint'(req_ready), 0);
            if (m_age < 4) begin
                chk("early_valid", longint'(out_valid), 0);
            end else begin
                chk("out_valid", longint'(out_valid), 1);
                chk("out_data", longint'($signed(out_data)), m_data);
                chk("out_id", longint'(out_id), longint'(m_id));
                if (out_ready) m_busy = 0;
            end
        end
    end

    task automatic set_req(input int r, input longint s, input int c);
        req_sum[r*DW +: DW] = DW'(s);
        req_cnt[r*6 +: 6]   = 6'(c);
    endtask

    task automatic wait_ready(output int g);
        g = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                return;
            end
        end
        chk("grant_timeout", 1, 0);
    endtask

    task automatic wait_out(output int n);
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        chk("out_timeout", 1, 0);
    endtask

    task automatic run_one(input int r, input longint s, input int c,
                           input longint expd, input int expid);
        int g, n;
        @(posedge clk); #1;
        set_req(r, s, c);
        req_valid = NREQ'(1) << r;
        out_ready = 1'b1;
        wait_ready(g);
        chk("dir_grant", longint'(g), longint'(r));
        @(posedge clk); #1;
        req_valid = '0;
        wait_out(n);
        chk("dir_latency", longint'(n), 4);
        chk("dir_data", longint'($signed(out_data)), expd);
        chk("dir_id", longint'(out_id), longint'(expid));
    endtask

    function automatic longint rand_sum();
        case ($urandom_range(0, 5))
            0:       return longint'(8388607);
            1:       return -longint'(8388608);
            default: return longint'($signed(DW'($urandom)));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, n;
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req_valid = '0;
        req_sum = '0;
        req_cnt = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin with all requesters held valid
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 100 * (i + 1), i);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_ready(g);
            chk($sformatf("rr_grant%0d", k), longint'(g), longint'(rr_exp[k]));
            @(posedge clk); #1;
            if (k == 4) req_valid = 4'b0101;
        end
        wait_ready(g);
        chk("rr_skip", longint'(g), 2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_out(n);

        // Directed arithmetic cases
        run_one(0, 640, 9, 64, 0);
        run_one(1, -9, 3, -2, 1);
        run_one(1, 100, 0, 100, 1);
        run_one(0, 8388607, 0, 32767, 0);
        run_one(0, -8388608, 0, -32768, 0);

        // Output stall: 1000 / 5 -> 200 held while out_ready is low
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_req(3, 1000, 4);
        req_valid = 4'b1000;
        wait_ready(g);
        @(posedge clk); #1;
        req_valid = 4'b0011;
        wait_out(n);
        for (int k = 0; k < 10; k++) begin
            chk("stall_data", longint'($signed(out_data)), 200);
            chk("stall_ready", longint'(req_ready), 0);
            chk("stall_valid", longint'(out_valid), 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_exit_busy", longint'(busy), 0);
        chk("stall_exit_valid", longint'(out_valid), 0);
        out_ready = 1'b1;

        // Reset while the request sits in MUL
        @(posedge clk); #1;
        set_req(1, 5000, 1);
        req_valid = 4'b0010;
        wait_ready(g);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mulrst_busy", longint'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mulrst_novalid", longint'(out_valid), 0);
        end
        @(posedge clk); #1;
        req_valid = '1;
        wait_ready(g);
        chk("mulrst_grant0", longint'(g), 0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_out(n);

        // Randomized traffic checked by the model
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) set_req(i, rand_sum(), int'($urandom_range(0, 63)));
            req_valid = NREQ'($urandom) & NREQ'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
